// File: rtl/nand_cpu_pkg.sv
// Shared front-end types: BTB entry layout and 2-bit counter encodings.
// `PC_SIZE sets the default PC width (16 when not supplied by the build).
`ifndef PC_SIZE
`define PC_SIZE 16
`endif

package nand_cpu_pkg;

  localparam int unsigned PKG_PC_W = `PC_SIZE;

  localparam logic [1:0] CTR_WEAK_TAKEN   = 2'b10;
  localparam logic [1:0] CTR_STRONG_TAKEN = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [PKG_PC_W-1:0] tag;
    logic [PKG_PC_W-1:0] target;
    logic [1:0]          ctr;
  } btb_entry_t;

endpackage

// File: rtl/branch_feedback_ifc.sv
// Branch resolution feedback from decode back to the fetch PC generator.
`ifndef PC_SIZE
`define PC_SIZE 16
`endif

interface branch_feedback_ifc #(
  parameter int PC_W = `PC_SIZE
);
  logic            valid;
  logic            branch;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] predict_target;
  logic [PC_W-1:0] feedback_target;
  logic            predict_taken;
  logic            feedback_taken;

  modport out (
    output valid, branch, pc, predict_target, feedback_target, predict_taken, feedback_taken
  );
  modport in (
    input  valid, branch, pc, predict_target, feedback_target, predict_taken, feedback_taken
  );
  modport master (
    output valid, branch, pc, predict_target, feedback_target, predict_taken, feedback_taken
  );
  modport slave (
    input  valid, branch, pc, predict_target, feedback_target, predict_taken, feedback_taken
  );
endinterface

// File: rtl/btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Combinational lookup from registered state; update lands on the clock edge.
`ifndef PC_SIZE
`define PC_SIZE 16
`endif

module btb
  import nand_cpu_pkg::*;
#(
  parameter int PC_W        = `PC_SIZE,
  parameter int BTB_ENTRIES = 8
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            lookup_taken,
  output logic [PC_W-1:0] lookup_target,
  input  logic            upd_valid,
  input  logic            upd_branch,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [PC_W-1:0] upd_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);

  btb_entry_t entry_q [BTB_ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [PC_W-1:0]  rd_tag;
  logic [PC_W-1:0]  wr_tag;
  logic             rd_hit;
  logic             wr_hit;

  function automatic logic [1:0] ctr_sat(input logic [1:0] ctr, input logic up);
    if (up) return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

  assign rd_idx = lookup_pc[IDX_W-1:0];
  assign rd_tag = lookup_pc >> IDX_W;
  assign wr_idx = upd_pc[IDX_W-1:0];
  assign wr_tag = upd_pc >> IDX_W;

  assign rd_hit = entry_q[rd_idx].valid && (entry_q[rd_idx].tag == PKG_PC_W'(rd_tag));
  assign wr_hit = entry_q[wr_idx].valid && (entry_q[wr_idx].tag == PKG_PC_W'(wr_tag));

  assign lookup_taken  = rd_hit & entry_q[rd_idx].ctr[1];
  assign lookup_target = PC_W'(entry_q[rd_idx].target);

  // Only the valid bits are reset; tag/target/ctr are qualified by valid.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) entry_q[i].valid <= 1'b0;
    end else if (upd_valid) begin
      if (wr_hit) begin
        if (upd_branch) entry_q[wr_idx].ctr <= ctr_sat(entry_q[wr_idx].ctr, upd_taken);
        else            entry_q[wr_idx].ctr <= CTR_STRONG_TAKEN;
        if (upd_taken)  entry_q[wr_idx].target <= PKG_PC_W'(upd_target);
      end else if (upd_taken) begin
        entry_q[wr_idx].valid  <= 1'b1;
        entry_q[wr_idx].tag    <= PKG_PC_W'(wr_tag);
        entry_q[wr_idx].target <= PKG_PC_W'(upd_target);
        entry_q[wr_idx].ctr    <= upd_branch ? CTR_WEAK_TAKEN : CTR_STRONG_TAKEN;
      end
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register, mispredict detection and next-PC selection.
// Define NAND_CPU_BTB_EN to build with the branch target buffer; otherwise fetch is always sequential.
`ifndef PC_SIZE
`define PC_SIZE 16
`endif

module fetch_pc_unit
  import nand_cpu_pkg::*;
#(
  parameter int PC_W        = `PC_SIZE,
  parameter int BTB_ENTRIES = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               i_stall,
  branch_feedback_ifc.in     i_branch_feedback,
  output logic [PC_W-1:0]    o_pc,
  output logic               o_predict_taken,
  output logic [PC_W-1:0]    o_predict_target,
  output logic               o_flush
);

  if ((BTB_ENTRIES < 2) || ((BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0)) begin : g_bad_btb_entries
    $error("BTB_ENTRIES must be a power of two and at least 2");
  end

  logic [PC_W-1:0] pc_p0;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] pc_plus1;
  logic            actual_taken;
  logic [PC_W-1:0] actual_next;
  logic            mispredict;

  assign pc_plus1 = pc_p0 + PC_W'(1);

  // Jumps (branch=0) are unconditionally taken.
  assign actual_taken = i_branch_feedback.branch ? i_branch_feedback.feedback_taken : 1'b1;
  assign actual_next  = actual_taken ? i_branch_feedback.feedback_target
                                     : i_branch_feedback.pc + PC_W'(1);

  assign mispredict = i_branch_feedback.valid &
                      ((i_branch_feedback.predict_taken != actual_taken) |
                       (actual_taken &
                        (i_branch_feedback.predict_target != i_branch_feedback.feedback_target)));

  assign o_flush = mispredict;

`ifdef NAND_CPU_BTB_EN
  logic            btb_taken;
  logic [PC_W-1:0] btb_target;

  btb #(
    .PC_W        (PC_W),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk           (clk),
    .n_rst         (n_rst),
    .lookup_pc     (pc_p0),
    .lookup_taken  (btb_taken),
    .lookup_target (btb_target),
    .upd_valid     (i_branch_feedback.valid),
    .upd_branch    (i_branch_feedback.branch),
    .upd_taken     (actual_taken),
    .upd_pc        (i_branch_feedback.pc),
    .upd_target    (i_branch_feedback.feedback_target)
  );

  assign o_predict_taken  = btb_taken;
  assign o_predict_target = btb_taken ? btb_target : pc_plus1;
`else
  assign o_predict_taken  = 1'b0;
  assign o_predict_target = pc_plus1;
`endif

  // A redirect must win over stall so the squashed path is never held.
  always_comb begin
    pc_next = o_predict_target;
    if (mispredict)   pc_next = actual_next;
    else if (i_stall) pc_next = pc_p0;
  end

  // Stage p0: architectural fetch PC
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) pc_p0 <= '0;
    else        pc_p0 <= pc_next;
  end

  assign o_pc = pc_p0;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit; the reference model tracks the BTB as plain arrays.
// Works with and without NAND_CPU_BTB_EN defined.
`timescale 1ns/1ps

module tb_fetch_pc_unit;

  localparam int PW = 16;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          i_stall;
  logic [PW-1:0] o_pc;
  logic          o_predict_taken;
  logic [PW-1:0] o_predict_target;
  logic          o_flush;

  branch_feedback_ifc #(.PC_W(PW)) fbi ();

  fetch_pc_unit #(.PC_W(PW), .BTB_ENTRIES(N)) dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .i_stall           (i_stall),
    .i_branch_feedback (fbi),
    .o_pc              (o_pc),
    .o_predict_taken   (o_predict_taken),
    .o_predict_target  (o_predict_target),
    .o_flush           (o_flush)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [PW-1:0] m_pc;
  bit            m_valid  [N];
  logic [PW-1:0] m_owner  [N];
  logic [PW-1:0] m_target [N];
  int            m_ctr    [N];

  function automatic bit m_hit(input logic [PW-1:0] pc);
    int idx;
    idx = int'(pc) % N;
    return m_valid[idx] && ((int'(m_owner[idx]) / N) == (int'(pc) / N));
  endfunction

  function automatic bit m_pred_taken(input logic [PW-1:0] pc);
`ifdef NAND_CPU_BTB_EN
    return m_hit(pc) && (m_ctr[int'(pc) % N] >= 2);
`else
    return (pc != pc) && m_hit(pc);
`endif
  endfunction

  function automatic logic [PW-1:0] m_pred_target(input logic [PW-1:0] pc);
    if (m_pred_taken(pc)) return m_target[int'(pc) % N];
    return pc + PW'(1);
  endfunction

  function automatic bit m_actual_taken();
    return fbi.branch ? fbi.feedback_taken : 1'b1;
  endfunction

  function automatic logic [PW-1:0] m_actual_next();
    return m_actual_taken() ? fbi.feedback_target : fbi.pc + PW'(1);
  endfunction

  function automatic bit m_flush();
    bit at;
    at = m_actual_taken();
    return fbi.valid && ((fbi.predict_taken != at) ||
                         (at && (fbi.predict_target != fbi.feedback_target)));
  endfunction

  task automatic m_reset();
    m_pc = '0;
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
  endtask

  task automatic m_btb_update();
    int idx;
    bit at;
    idx = int'(fbi.pc) % N;
    at  = m_actual_taken();
    if (m_hit(fbi.pc)) begin
      if (fbi.branch) m_ctr[idx] = at ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                                      : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
      else            m_ctr[idx] = 3;
      if (at) m_target[idx] = fbi.feedback_target;
    end else if (at) begin
      m_valid[idx]  = 1'b1;
      m_owner[idx]  = fbi.pc;
      m_target[idx] = fbi.feedback_target;
      m_ctr[idx]    = fbi.branch ? 2 : 3;
    end
  endtask

  // Advance one clock: model next state is computed from pre-edge inputs.
  task automatic tick();
    logic [PW-1:0] nxt;
    nxt = m_flush() ? m_actual_next() : (i_stall ? m_pc : m_pred_target(m_pc));
    if (fbi.valid) m_btb_update();
    @(posedge clk);
    #1;
    m_pc = nxt;
    @(negedge clk);
  endtask

  // Predict fields are filled from the model, as decode would carry them.
  task automatic set_fb(input bit v, input bit br, input logic [PW-1:0] pc,
                        input logic [PW-1:0] tgt, input bit tk);
    fbi.valid           = v;
    fbi.branch          = br;
    fbi.pc              = pc;
    fbi.feedback_target = tgt;
    fbi.feedback_taken  = tk;
    fbi.predict_taken   = m_pred_taken(pc);
    fbi.predict_target  = m_pred_target(pc);
  endtask

  task automatic clear_fb();
    set_fb(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic redirect(input logic [PW-1:0] tgt, input logic [PW-1:0] fbpc);
    set_fb(1'b1, 1'b0, fbpc, tgt, 1'b1);
    tick();
    clear_fb();
  endtask

  task automatic test_reset();
    n_rst   = 1'b0;
    i_stall = 1'b0;
    m_reset();
    clear_fb();
    #12;
    checks++; if (o_pc !== 16'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", o_pc, 16'h0); end
    checks++; if (o_predict_taken !== 1'b0) begin errors++; $display("FAIL reset_ptaken got=%b exp=0", o_predict_taken); end
    checks++; if (o_predict_target !== 16'h1) begin errors++; $display("FAIL reset_ptarget got=%h exp=%h", o_predict_target, 16'h1); end
    checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", o_flush); end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_sequential();
    logic [PW-1:0] e;
    for (int i = 0; i < 4; i++) begin
      e = PW'(i);
      #1;
      checks++; if (o_pc !== e) begin errors++; $display("FAIL seq_pc got=%h exp=%h", o_pc, e); end
      checks++; if (o_predict_taken !== 1'b0) begin errors++; $display("FAIL seq_ptaken got=%b exp=0", o_predict_taken); end
      checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL seq_flush got=%b exp=0", o_flush); end
      tick();
    end
    tick();
    checks++; if (o_pc !== 16'h5) begin errors++; $display("FAIL seq_pc5 got=%h exp=%h", o_pc, 16'h5); end
  endtask

  task automatic test_stall();
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (o_pc !== 16'h5) begin errors++; $display("FAIL stall_hold got=%h exp=%h", o_pc, 16'h5); end
    end
    i_stall = 1'b0;
    tick();
    checks++; if (o_pc !== 16'h6) begin errors++; $display("FAIL stall_resume got=%h exp=%h", o_pc, 16'h6); end
  endtask

  task automatic test_branch_alloc();
    set_fb(1'b1, 1'b1, 16'h4, 16'h20, 1'b1);
    #1;
    checks++; if (o_flush !== 1'b1) begin errors++; $display("FAIL alloc_flush got=%b exp=1", o_flush); end
    tick();
    clear_fb();
    checks++; if (o_pc !== 16'h20) begin errors++; $display("FAIL alloc_redirect got=%h exp=%h", o_pc, 16'h20); end
    redirect(16'h4, 16'h13);
    #1;
    checks++; if (o_pc !== 16'h4) begin errors++; $display("FAIL hit_pc got=%h exp=%h", o_pc, 16'h4); end
    checks++; if (o_predict_taken !== m_pred_taken(m_pc)) begin errors++; $display("FAIL hit_ptaken got=%b exp=%b", o_predict_taken, m_pred_taken(m_pc)); end
    checks++; if (o_predict_target !== m_pred_target(m_pc)) begin errors++; $display("FAIL hit_ptarget got=%h exp=%h", o_predict_target, m_pred_target(m_pc)); end
`ifdef NAND_CPU_BTB_EN
    checks++; if (o_predict_target !== 16'h20) begin errors++; $display("FAIL hit_target20 got=%h exp=%h", o_predict_target, 16'h20); end
`endif
    tick();
    checks++; if (o_pc !== m_pc) begin errors++; $display("FAIL hit_next got=%h exp=%h", o_pc, m_pc); end
  endtask

  task automatic test_counter_decay();
    bit ef;
    for (int k = 0; k < 2; k++) begin
      set_fb(1'b1, 1'b1, 16'h4, 16'h20, 1'b0);
      ef = m_flush();
      #1;
      checks++; if (o_flush !== ef) begin errors++; $display("FAIL decay_flush%0d got=%b exp=%b", k, o_flush, ef); end
      tick();
      clear_fb();
      checks++; if (o_pc !== m_pc) begin errors++; $display("FAIL decay_pc%0d got=%h exp=%h", k, o_pc, m_pc); end
`ifdef NAND_CPU_BTB_EN
      if (k == 0) begin
        checks++; if (o_pc !== 16'h5) begin errors++; $display("FAIL decay_pc5 got=%h exp=%h", o_pc, 16'h5); end
      end
`endif
    end
    redirect(16'h4, 16'h11);
    #1;
    checks++; if (o_predict_taken !== 1'b0) begin errors++; $display("FAIL decay_ptaken got=%b exp=0", o_predict_taken); end
    checks++; if (o_predict_target !== 16'h5) begin errors++; $display("FAIL decay_ptarget got=%h exp=%h", o_predict_target, 16'h5); end
  endtask

  task automatic test_redirect_beats_stall();
    i_stall = 1'b1;
    set_fb(1'b1, 1'b0, 16'h9, 16'h40, 1'b1);
    #1;
    checks++; if (o_flush !== 1'b1) begin errors++; $display("FAIL rbs_flush got=%b exp=1", o_flush); end
    tick();
    clear_fb();
    checks++; if (o_pc !== 16'h40) begin errors++; $display("FAIL rbs_pc got=%h exp=%h", o_pc, 16'h40); end
    tick();
    checks++; if (o_pc !== 16'h40) begin errors++; $display("FAIL rbs_hold got=%h exp=%h", o_pc, 16'h40); end
    i_stall = 1'b0;
  endtask

  task automatic test_wrap();
    redirect(16'hFFFF, 16'h1A);
    #1;
    checks++; if (o_pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_pc got=%h exp=%h", o_pc, 16'hFFFF); end
    checks++; if (o_predict_taken !== 1'b0) begin errors++; $display("FAIL wrap_ptaken got=%b exp=0", o_predict_taken); end
    checks++; if (o_predict_target !== 16'h0) begin errors++; $display("FAIL wrap_ptarget got=%h exp=%h", o_predict_target, 16'h0); end
    tick();
    checks++; if (o_pc !== 16'h0) begin errors++; $display("FAIL wrap_next got=%h exp=%h", o_pc, 16'h0); end
  endtask

  task automatic test_async_reset();
    bit ef;
    for (int i = 0; i < 4; i++) begin
      if (!m_pred_taken(16'h4)) begin
        set_fb(1'b1, 1'b1, 16'h4, 16'h20, 1'b1);
        ef = m_flush();
        #1;
        checks++; if (o_flush !== ef) begin errors++; $display("FAIL train_flush got=%b exp=%b", o_flush, ef); end
        tick();
        clear_fb();
      end
    end
    redirect(16'h4, 16'h1B);
    #1;
    checks++; if (o_predict_taken !== m_pred_taken(16'h4)) begin errors++; $display("FAIL pre_rst_ptaken got=%b exp=%b", o_predict_taken, m_pred_taken(16'h4)); end
`ifdef NAND_CPU_BTB_EN
    checks++; if (o_predict_taken !== 1'b1) begin errors++; $display("FAIL pre_rst_hit got=%b exp=1", o_predict_taken); end
`endif
    #2;
    n_rst = 1'b0;
    #1;
    m_reset();
    checks++; if (o_pc !== 16'h0) begin errors++; $display("FAIL arst_pc got=%h exp=%h", o_pc, 16'h0); end
    checks++; if (o_predict_target !== 16'h1) begin errors++; $display("FAIL arst_ptarget got=%h exp=%h", o_predict_target, 16'h1); end
    @(negedge clk);
    n_rst = 1'b1;
    redirect(16'h4, 16'h1D);
    #1;
    checks++; if (o_pc !== 16'h4) begin errors++; $display("FAIL post_rst_pc got=%h exp=%h", o_pc, 16'h4); end
    checks++; if (o_predict_taken !== 1'b0) begin errors++; $display("FAIL post_rst_ptaken got=%b exp=0", o_predict_taken); end
    checks++; if (o_predict_target !== 16'h5) begin errors++; $display("FAIL post_rst_ptarget got=%h exp=%h", o_predict_target, 16'h5); end
  endtask

  task automatic test_random();
    logic [PW-1:0] tgt;
    logic [PW-1:0] fpc;
    bit ef;
    for (int n = 0; n < 400; n++) begin
      i_stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) < 4) begin
        case ($urandom_range(0, 3))
          0:       tgt = 16'h20;
          1:       tgt = 16'h40;
          2:       tgt = 16'h4;
          default: tgt = PW'($urandom_range(0, 31));
        endcase
        fpc = ($urandom_range(0, 3) == 0) ? m_pc : PW'($urandom_range(0, 31));
        set_fb(1'b1, 1'($urandom_range(0, 1)), fpc, tgt, 1'($urandom_range(0, 1)));
      end else begin
        clear_fb();
      end
      ef = m_flush();
      #1;
      checks++; if (o_flush !== ef) begin errors++; $display("FAIL rnd_flush n=%0d got=%b exp=%b", n, o_flush, ef); end
      checks++; if (o_predict_taken !== m_pred_taken(m_pc)) begin errors++; $display("FAIL rnd_ptaken n=%0d got=%b exp=%b", n, o_predict_taken, m_pred_taken(m_pc)); end
      checks++; if (o_predict_target !== m_pred_target(m_pc)) begin errors++; $display("FAIL rnd_ptarget n=%0d got=%h exp=%h", n, o_predict_target, m_pred_target(m_pc)); end
      tick();
      checks++; if (o_pc !== m_pc) begin errors++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, o_pc, m_pc); end
    end
    clear_fb();
    i_stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_alloc();
    test_counter_decay();
    test_redirect_beats_stall();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
